// File: rtl/fp_sub_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_sub_seq
// Purpose  : Sequential IEEE 754 single-precision subtractor, result = a - b.
//            Truncating arithmetic (no rounding), denormals accepted, no
//            NaN/Inf special cases. Post-subtraction normalization shifts one
//            bit per cycle to keep the critical path short.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            start  - request, sampled only while idle
//            a, b   - minuend / subtrahend (IEEE 754 single)
//            busy   - high whenever the unit is not idle
//            done   - one-cycle pulse, result valid in the same cycle
//            result - registered a - b, held until the next done
// Revision : 1.0 - initial release
// ============================================================================
module fp_sub_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [2:0] C_IDLE   = 3'd0;
  localparam logic [2:0] C_ALIGN  = 3'd1;
  localparam logic [2:0] C_ADDSUB = 3'd2;
  localparam logic [2:0] C_NORM   = 3'd3;
  localparam logic [2:0] C_DONE   = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic [31:0] r_a;
  logic [31:0] r_bn;     // subtrahend with its sign flipped: a - b == a + bn
  logic [23:0] r_ma;
  logic [23:0] r_mb;
  logic [7:0]  r_exp;
  logic        r_sign;
  logic [23:0] r_mant;
  logic [31:0] r_result;

  // Operand capture and zero-operand shortcut
  logic [31:0] w_bn;
  logic        w_a_zero;
  logic        w_b_zero;
  assign w_bn     = {~b[31], b[30:0]};
  assign w_a_zero = (a[30:0] == 31'd0);
  assign w_b_zero = (b[30:0] == 31'd0);

  // Alignment: hidden bit is 1 only for a nonzero exponent
  logic [7:0]  w_ea;
  logic [7:0]  w_eb;
  logic [23:0] w_ma_raw;
  logic [23:0] w_mb_raw;
  logic        w_a_ge;
  logic [7:0]  w_diff;
  logic [23:0] w_ma_al;
  logic [23:0] w_mb_al;
  assign w_ea     = r_a[30:23];
  assign w_eb     = r_bn[30:23];
  assign w_ma_raw = {(w_ea != 8'd0), r_a[22:0]};
  assign w_mb_raw = {(w_eb != 8'd0), r_bn[22:0]};
  assign w_a_ge   = (w_ea >= w_eb);
  assign w_diff   = w_a_ge ? (w_ea - w_eb) : (w_eb - w_ea);
  assign w_ma_al  = w_a_ge ? w_ma_raw : ((w_diff >= 8'd24) ? 24'd0 : (w_ma_raw >> w_diff));
  assign w_mb_al  = !w_a_ge ? w_mb_raw : ((w_diff >= 8'd24) ? 24'd0 : (w_mb_raw >> w_diff));

  // Add/subtract of aligned magnitudes; with differing signs the larger
  // magnitude sets the sign (a tie yields zero, so its sign is irrelevant
  // except that a's sign is selected).
  logic        w_same;
  logic        w_ma_ge;
  logic [24:0] w_sum;
  logic        w_sign;
  logic [7:0]  w_exp_inc;
  assign w_same    = (r_a[31] == r_bn[31]);
  assign w_ma_ge   = (r_ma >= r_mb);
  assign w_sum     = w_same  ? ({1'b0, r_ma} + {1'b0, r_mb}) :
                     w_ma_ge ? ({1'b0, r_ma} - {1'b0, r_mb}) :
                               ({1'b0, r_mb} - {1'b0, r_ma});
  assign w_sign    = (w_same || w_ma_ge) ? r_a[31] : r_bn[31];
  assign w_exp_inc = r_exp + 8'd1;   // wraps at 255 by design

  // Normalization keeps shifting until the leading one reaches bit 23 or the
  // exponent bottoms out at 0 (denormal encoding).
  logic w_norm_shift;
  assign w_norm_shift = !r_mant[23] && (r_exp != 8'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= C_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = C_IDLE;
    case (r_state)
      C_IDLE: begin
        if (!start)                 w_next_state = C_IDLE;
        else if (w_a_zero || w_b_zero) w_next_state = C_DONE;
        else                        w_next_state = C_ALIGN;
      end
      C_ALIGN:  w_next_state = C_ADDSUB;
      C_ADDSUB: w_next_state = ((w_sum == 25'd0) || w_sum[24]) ? C_DONE : C_NORM;
      C_NORM:   w_next_state = w_norm_shift ? C_NORM : C_DONE;
      C_DONE:   w_next_state = C_IDLE;
      default:  w_next_state = C_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (r_state != C_IDLE);
    done = (r_state == C_DONE);
  end
  assign result = r_result;

  // Datapath registers; r_result is written only on transitions into DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= 32'd0;
      r_bn     <= 32'd0;
      r_ma     <= 24'd0;
      r_mb     <= 24'd0;
      r_exp    <= 8'd0;
      r_sign   <= 1'b0;
      r_mant   <= 24'd0;
      r_result <= 32'd0;
    end else begin
      case (r_state)
        C_IDLE: begin
          if (start) begin
            r_a  <= a;
            r_bn <= w_bn;
            // a == 0 is tested first, so 0 - (+0) gives -0
            if (w_a_zero)      r_result <= w_bn;
            else if (w_b_zero) r_result <= a;
          end
        end
        C_ALIGN: begin
          r_exp <= w_a_ge ? w_ea : w_eb;
          r_ma  <= w_ma_al;
          r_mb  <= w_mb_al;
        end
        C_ADDSUB: begin
          r_sign <= w_sign;
          if (w_sum == 25'd0) begin
            r_result <= 32'd0;
          end else if (w_sum[24]) begin
            r_mant   <= w_sum[24:1];
            r_exp    <= w_exp_inc;
            r_result <= {w_sign, w_exp_inc, w_sum[23:1]};
          end else begin
            r_mant <= w_sum[23:0];
          end
        end
        C_NORM: begin
          if (w_norm_shift) begin
            r_mant <= {r_mant[22:0], 1'b0};
            r_exp  <= r_exp - 8'd1;
          end else begin
            r_result <= {r_sign, r_exp, r_mant[22:0]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_sub_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_sub_seq
// Purpose  : Self-checking bench for fp_sub_seq. A driver issues operations
//            and pushes expected result/latency into a queue; a monitor pops
//            and compares on every done pulse. Random operations are checked
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_sub_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  fp_sub_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          e;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_res = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: exact integer arithmetic on aligned significands,
  // then the truncating normalization rules.
  function automatic void ref_sub(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output int lat);
    logic [31:0] yn;
    int ex, ey, mx, my, e, s, mag, n;
    logic sg;
    yn = y ^ 32'h8000_0000;
    if (x[30:0] == 31'd0) begin r = yn; lat = 1; return; end
    if (y[30:0] == 31'd0) begin r = x;  lat = 1; return; end
    ex = int'(x[30:23]);
    ey = int'(yn[30:23]);
    mx = ((ex != 0) ? (1 << 23) : 0) + int'(x[22:0]);
    my = ((ey != 0) ? (1 << 23) : 0) + int'(yn[22:0]);
    if (ex >= ey) begin
      e  = ex;
      my = (ex - ey >= 24) ? 0 : (my >> (ex - ey));
    end else begin
      e  = ey;
      mx = (ey - ex >= 24) ? 0 : (mx >> (ey - ex));
    end
    s   = (x[31] ? -mx : mx) + (yn[31] ? -my : my);
    sg  = (s < 0);
    mag = sg ? -s : s;
    if (mag == 0) begin
      r = 32'd0; lat = 3;
    end else if (mag >= (1 << 24)) begin
      r = {sg, 8'(e + 1), 23'(mag >> 1)}; lat = 3;
    end else begin
      n = 0;
      while (mag < (1 << 23) && e > 0) begin
        mag = mag << 1; e = e - 1; n = n + 1;
      end
      r = {sg, 8'(e), 23'(mag)}; lat = 4 + n;
    end
  endfunction

  // Monitor: every done must match the oldest expectation; between done
  // pulses the result must hold.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t ex;
        ex = sb_q.pop_front();
        check("result", result, ex.res);
        check("latency", 32'(cyc - ex.e + 1), 32'(ex.lat));
        check("busy_in_done", {31'd0, busy}, 32'd1);
        last_res = ex.res;
      end
    end else begin
      check("result_hold", result, last_res);
    end
  end

  // Issue one operation: start stays high until the DUT samples it idle.
  // Returns the cycle number of the sampling edge.
  task automatic issue(input logic [31:0] xa, input logic [31:0] xb,
                       input logic [31:0] xres, input int xlat, output int e);
    logic pre;
    int   guard;
    @(negedge clk);
    a = xa; b = xb; start = 1'b1;
    guard = 0;
    do begin
      pre = busy;
      @(posedge clk); #1;
      guard++;
    end while (pre && guard < 100);
    if (pre) check("start_timeout", 32'd1, 32'd0);
    e = cyc;
    start = 1'b0;
    a = $urandom; b = $urandom;   // operands must not matter after sampling
    sb_q.push_back('{res: xres, lat: xlat, e: e});
  endtask

  task automatic issue_model(input logic [31:0] xa, input logic [31:0] xb);
    logic [31:0] r;
    int          l;
    int          e;
    ref_sub(xa, xb, r, l);
    issue(xa, xb, r, l, e);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb_q.size() != 0 || busy) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() != 0) check("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] rand_operand(input logic [31:0] base);
    logic [31:0] v;
    logic [31:0] d;
    int          k;
    k = $urandom_range(0, 6);
    v = $urandom;
    d = $urandom_range(0, 3);
    case (k)
      0, 1: ;
      2:    v[30:0] = 31'd0;                                         // zero
      3:    v = base ^ ($urandom_range(0, 1) ? 32'h8000_0000 : 32'd0); // tie
      4:    v = {v[31], base[30:23], v[22:0]};                       // same exp
      5:    v = {v[31], base[30:23] + d[7:0], v[22:0]};              // near exp
      default: v[30:23] = 8'd0;                                      // denormal
    endcase
    return v;
  endfunction

  initial begin
    int e;
    int guard;
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n = 1'b0; start = 1'b0; a = 32'd0; b = 32'd0;
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // 3.0 - 1.0, busy profile over cycles 1..5
    issue(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4, e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("busy_profile", {31'd0, busy}, (i < 4) ? 32'd1 : 32'd0);
    end
    drain();

    issue(32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 3, e);   // carry
    issue(32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 3, e);   // zero sum
    issue(32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 1, e);   // 0 - (+0)
    drain();

    // 23 shifts with start pulsed while busy
    issue(32'h3F80_0001, 32'h3F80_0000, 32'h3400_0000, 27, e);
    guard = 0;
    while (busy && guard < 60) begin
      @(negedge clk);
      guard++;
      if (busy && !done) begin
        start = 1'($urandom_range(0, 1));
        a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    drain();

    // Shortcut paths back to back: start held into the done cycle
    issue(32'h0000_0000, 32'h40A0_0000, 32'hC0A0_0000, 1, e);
    issue(32'h40A0_0000, 32'h0000_0000, 32'h40A0_0000, 1, e);
    drain();

    // Reset in the middle of a long operation
    issue(32'h3F80_0001, 32'h3F80_0000, 32'h3400_0000, 27, e);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    sb_q.delete();
    last_res = 32'd0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);   // a surviving operation would raise done here
    issue(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4, e);
    drain();

    // Randomized operations against the reference model
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 5) == 0) ra[30:23] = 8'd0;
      rb = rand_operand(ra);
      if ($urandom_range(0, 9) == 0) ra[30:0] = 31'd0;
      issue_model(ra, rb);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
